// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and line levels.
// Used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// TX data shifter: holds the word LSB-first and counts emitted data bits.
// ser_done marks the cycle in which the last data bit is on the line.
module tx_serializer #(
    parameter int Data_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  step,
    input  logic [Data_Width-1:0] data_in,
    output logic                  bit_out,
    output logic                  ser_done
);

    localparam int CW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [CW-1:0] LAST = CW'(Data_Width - 1);

    logic [Data_Width-1:0] sreg;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data_in;
            cnt  <= '0;
        end else begin
            if (shift)
                sreg <= sreg >> 1;
            // Saturate so the count never wraps past the last bit
            if (step && cnt != LAST)
                cnt <= cnt + CW'(1);
        end
    end

    assign bit_out  = sreg[0];
    assign ser_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// One bit per clk; tx_out and busy both come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Data_Width-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    uart_state_t state, state_nx;
    logic        tx_nx, busy_nx;
    logic        load, shift, step;
    logic        bit_out, ser_done;
    logic        par_en_q, par_bit;

    tx_serializer #(
        .Data_Width(Data_Width)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .step    (step),
        .data_in (p_data),
        .bit_out (bit_out),
        .ser_done(ser_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_out   <= IDLE_LEVEL;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state  <= state_nx;
            tx_out <= tx_nx;
            busy   <= busy_nx;
            if (load) begin
                par_en_q <= par_en;
                par_bit  <= (par_typ == PAR_ODD) ? ~^p_data : ^p_data;
            end
        end
    end

    always_comb begin
        state_nx = IDLE;
        tx_nx    = IDLE_LEVEL;
        busy_nx  = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    state_nx = START;
                    tx_nx    = START_BIT;
                    busy_nx  = 1'b1;
                    load     = 1'b1;
                end
            end
            START: begin
                state_nx = DATA;
                tx_nx    = bit_out;
                busy_nx  = 1'b1;
                shift    = 1'b1;
            end
            DATA: begin
                busy_nx = 1'b1;
                if (ser_done) begin
                    state_nx = par_en_q ? PARITY : STOP;
                    tx_nx    = par_en_q ? par_bit : STOP_BIT;
                end else begin
                    state_nx = DATA;
                    tx_nx    = bit_out;
                    shift    = 1'b1;
                    step     = 1'b1;
                end
            end
            PARITY: begin
                state_nx = STOP;
                tx_nx    = STOP_BIT;
                busy_nx  = 1'b1;
            end
            STOP: begin
                state_nx = IDLE;
                tx_nx    = IDLE_LEVEL;
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with hand-written bit sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.Data_Width(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Sample each frame bit on the falling edge, then the idle gap
    task automatic check_frame(input string tag, input string bits);
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            check($sformatf("%s_tx%0d", tag, i), {7'd0, tx_out},
                  (bits[i] == "1") ? 8'd1 : 8'd0);
            check($sformatf("%s_busy%0d", tag, i), {7'd0, busy}, 8'd1);
        end
        @(negedge clk);
        check({tag, "_idle_tx"}, {7'd0, tx_out}, 8'd1);
        check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    endtask

    // One-cycle request; inputs are scrambled right after acceptance
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {7'd0, tx_out}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx%0d", i), {7'd0, tx_out}, 8'd1);
            check($sformatf("idle_busy%0d", i), {7'd0, busy}, 8'd0);
        end

        send(8'hA5, 1'b1, 1'b0);
        check_frame("even_a5", "01010010101");

        send(8'h00, 1'b1, 1'b1);
        check_frame("odd_00", "00000000011");

        send(8'hFF, 1'b0, 1'b0);
        check_frame("nopar_ff", "0111111111");

        // Back-to-back with valid held; new word appears mid-frame
        @(negedge clk);
        p_data     = 8'h3C;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        p_data  = 8'hC3;
        par_typ = 1'b1;
        check_frame("b2b_3c", "0001111001");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("b2b_c3_tx%0d", i), {7'd0, tx_out},
                  (i == 0 || i == 3 || i == 4 || i == 5 || i == 6)
                  ? 8'd0 : 8'd1);
            check($sformatf("b2b_c3_busy%0d", i), {7'd0, busy}, 8'd1);
        end
        data_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("b2b_end_tx", {7'd0, tx_out}, 8'd1);
            check("b2b_end_busy", {7'd0, busy}, 8'd0);
        end

        // Abort during data bit 4 (start + bits 0..3 already sent)
        send(8'h5A, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("pre_abort_busy", {7'd0, busy}, 8'd1);
        check("pre_abort_bit4", {7'd0, tx_out}, 8'd1);
        rst = 1'b0;
        #1;
        check("abort_tx", {7'd0, tx_out}, 8'd1);
        check("abort_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_abort_tx", {7'd0, tx_out}, 8'd1);
        check("post_abort_busy", {7'd0, busy}, 8'd0);

        send(8'h5A, 1'b0, 1'b0);
        check_frame("resume_5a", "0010110101");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
